// File: rtl/half_add_mon_pkg.sv
// Shared types and constants for the half-adder stream monitor.
// Holds the FSM state encoding, the expected half-adder pattern and the SYNC timeout.
package half_add_mon_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SYNC  = 2'd1,
      ST_CHECK = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   localparam int SYNC_TIMEOUT = 8;
   localparam int TMO_W        = $clog2(SYNC_TIMEOUT);

   // Expected {carry,sum} per phase: half-add of the two bits of a 2-bit count.
   localparam logic [3:0][1:0] EXP_PAT = {2'b10, 2'b01, 2'b01, 2'b00};

endpackage

// File: rtl/half_add_monitor_sat_counter.sv
// Saturating accumulator: adds inc when en, clamps at all-ones, synchronous clear wins over en.
module sat_counter #(
   parameter int W = 8
) (
   input  logic         clock,
   input  logic         clear,
   input  logic         sclr,
   input  logic         en,
   input  logic [W-1:0] inc,
   output logic [W-1:0] count
);

   logic [W-1:0] count_q, count_d;
   logic [W:0]   sum;

   always_comb begin
      sum     = {1'b0, count_q} + {1'b0, inc};
      count_d = count_q;
      if (sclr)
         count_d = '0;
      else if (en)
         count_d = sum[W] ? '1 : sum[W-1:0];
   end

   always_ff @(posedge clock or negedge clear) begin
      if (!clear) count_q <= '0;
      else        count_q <= count_d;
   end

   assign count = count_q;

endmodule

// File: rtl/half_add_monitor.sv
// Locks onto a half-adder sample stream at upstream count 3, then checks WINDOW samples
// against the expected pattern, counting mismatches and accumulating the sample values.
module half_add_monitor
   import half_add_mon_pkg::*;
#(
   parameter int WINDOW = 16,
   parameter int CNT_W  = 8
) (
   input  logic             clock,
   input  logic             clear,
   input  logic             start,
   input  logic             sum_in,
   input  logic             carry_in,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic             sync_fail,
   output logic [CNT_W-1:0] err_count,
   output logic [CNT_W-1:0] total
);

   state_e           state_q, state_d;
   logic [1:0]       phase_q, phase_d;
   logic [7:0]       samp_q, samp_d;
   logic [TMO_W-1:0] tmo_q, tmo_d;
   logic             sync_fail_q, sync_fail_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             pass_q, pass_d;
   logic             accept, in_check, mismatch;
   logic [CNT_W-1:0] err_q, tot_q, tot_inc;

   always_comb begin
      accept      = start && (state_q == ST_IDLE || state_q == ST_DONE);
      in_check    = (state_q == ST_CHECK);
      mismatch    = in_check && ({carry_in, sum_in} != EXP_PAT[phase_q]);
      tot_inc     = CNT_W'({carry_in, sum_in});
      state_d     = state_q;
      phase_d     = phase_q;
      samp_d      = samp_q;
      tmo_d       = tmo_q;
      sync_fail_d = sync_fail_q;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_d     = ST_SYNC;
               phase_d     = 2'd0;
               samp_d      = 8'd0;
               tmo_d       = '0;
               sync_fail_d = 1'b0;
            end
         end
         ST_SYNC: begin
            // (sum=0, carry=1) is upstream count 3, so the next sample is phase 0.
            if (!sum_in && carry_in) begin
               state_d = ST_CHECK;
               phase_d = 2'd0;
            end else if (tmo_q == TMO_W'(SYNC_TIMEOUT - 1)) begin
               state_d     = ST_DONE;
               sync_fail_d = 1'b1;
            end else begin
               tmo_d = tmo_q + TMO_W'(1);
            end
         end
         ST_CHECK: begin
            phase_d = phase_q + 2'd1;
            samp_d  = samp_q + 8'd1;
            if (samp_q == 8'(WINDOW - 1))
               state_d = ST_DONE;
         end
         default: state_d = ST_IDLE;
      endcase
      busy_d = (state_d == ST_SYNC) || (state_d == ST_CHECK);
      done_d = (state_d == ST_DONE);
      // err_q lags by one sample, so fold in the mismatch being registered this edge.
      pass_d = done_d && !sync_fail_d && (err_q == '0) && !mismatch;
   end

   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         state_q     <= ST_IDLE;
         phase_q     <= 2'd0;
         samp_q      <= 8'd0;
         tmo_q       <= '0;
         sync_fail_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         pass_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         phase_q     <= phase_d;
         samp_q      <= samp_d;
         tmo_q       <= tmo_d;
         sync_fail_q <= sync_fail_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         pass_q      <= pass_d;
      end
   end

   sat_counter #(.W(CNT_W)) u_err (
      .clock (clock),
      .clear (clear),
      .sclr  (accept),
      .en    (mismatch),
      .inc   (CNT_W'(1)),
      .count (err_q)
   );

   sat_counter #(.W(CNT_W)) u_tot (
      .clock (clock),
      .clear (clear),
      .sclr  (accept),
      .en    (in_check),
      .inc   (tot_inc),
      .count (tot_q)
   );

   assign busy      = busy_q;
   assign done      = done_q;
   assign pass      = pass_q;
   assign sync_fail = sync_fail_q;
   assign err_count = err_q;
   assign total     = tot_q;

endmodule

// File: tb/tb_half_add_monitor.sv
// Bench for half_add_monitor: a default instance and a CNT_W=4 instance share one stimulus stream.
module tb_half_add_monitor;

   localparam int W    = 16;
   localparam int TMO  = 8;
   localparam int CAP8 = 255;
   localparam int CAP4 = 15;

   logic clock, clear, start, sum_in, carry_in;
   logic busy, done, pass, sync_fail;
   logic [7:0] err_count, total;
   logic s_busy, s_done, s_pass, s_sync_fail;
   logic [3:0] s_err_count, s_total;

   int n_chk  = 0;
   int n_fail = 0;

   logic [1:0] seq [$];
   int exp_e8 [$], exp_t8 [$], exp_e4 [$], exp_t4 [$];

   half_add_monitor #(.WINDOW(W), .CNT_W(8)) u_dut (
      .clock(clock), .clear(clear), .start(start), .sum_in(sum_in), .carry_in(carry_in),
      .busy(busy), .done(done), .pass(pass), .sync_fail(sync_fail),
      .err_count(err_count), .total(total)
   );

   half_add_monitor #(.WINDOW(W), .CNT_W(4)) u_sat (
      .clock(clock), .clear(clear), .start(start), .sum_in(sum_in), .carry_in(carry_in),
      .busy(s_busy), .done(s_done), .pass(s_pass), .sync_fail(s_sync_fail),
      .err_count(s_err_count), .total(s_total)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Upstream 2-bit counter c: bits a,b half-added give a+b = {carry,sum}.
   task automatic build(input int c0, input int fault_pct);
      int c, v;
      seq.delete();
      for (int i = 0; i < TMO + W + 4; i++) begin
         c = (c0 + i) % 4;
         v = (c % 2) + (c / 2);
         seq.push_back(2'(v));
         if (int'($urandom_range(99)) < fault_pct) seq[i] = 2'($urandom_range(3));
      end
   endtask

   function automatic int sat(input int x, input int cap);
      return (x > cap) ? cap : x;
   endfunction

   // Expected err/total after every cycle, cycles until done, and sync failure.
   task automatic model(output int cyc, output bit sf);
      int s, c, e8, t8, e4, t4;
      logic [1:0] want;
      exp_e8.delete(); exp_t8.delete(); exp_e4.delete(); exp_t4.delete();
      s = -1;
      for (int i = 0; i < TMO; i++) if (s < 0 && seq[i] == 2'b10) s = i;
      sf  = (s < 0);
      cyc = sf ? TMO : s + 1 + W;
      e8 = 0; t8 = 0; e4 = 0; t4 = 0;
      for (int i = 0; i < cyc; i++) begin
         if (!sf && i > s) begin
            c    = (i - s - 1) % 4;
            want = 2'((c % 2) + (c / 2));
            if (seq[i] != want) begin
               e8 = sat(e8 + 1, CAP8);
               e4 = sat(e4 + 1, CAP4);
            end
            t8 = sat(t8 + int'(seq[i]), CAP8);
            t4 = sat(t4 + int'(seq[i]), CAP4);
         end
         exp_e8.push_back(e8); exp_t8.push_back(t8);
         exp_e4.push_back(e4); exp_t4.push_back(t4);
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_busy"},  32'(busy), 0);
      chk({tag, "_done"},  32'(done), 0);
      chk({tag, "_pass"},  32'(pass), 0);
      chk({tag, "_sf"},    32'(sync_fail), 0);
      chk({tag, "_err"},   32'(err_count), 0);
      chk({tag, "_tot"},   32'(total), 0);
      chk({tag, "_s_err"}, 32'(s_err_count), 0);
      chk({tag, "_s_tot"}, 32'(s_total), 0);
   endtask

   // Entered and left at posedge+1. start_at/abort_at are cycle indices (-1 = unused).
   task automatic run_seq(input string tag, input int start_at, input int abort_at);
      int cyc;
      bit sf, ep, last;
      model(cyc, sf);
      ep = !sf && (exp_e8[cyc-1] == 0);
      start = 1'b1; sum_in = 1'b0; carry_in = 1'b0;
      @(posedge clock); #1;
      start = 1'b0;
      chk({tag, "_start_busy"}, 32'(busy), 1);
      chk({tag, "_start_done"}, 32'(done), 0);
      chk({tag, "_start_err"},  32'(err_count), 0);
      chk({tag, "_start_tot"},  32'(total), 0);
      for (int i = 0; i < cyc; i++) begin
         if (i == abort_at) begin
            clear = 1'b0;
            #1;
            chk_zero({tag, "_abort"});
            @(negedge clock); clear = 1'b1;
            @(posedge clock); #1;
            chk_zero({tag, "_post_abort"});
            return;
         end
         {carry_in, sum_in} = seq[i];
         start = (i == start_at);
         @(posedge clock); #1;
         start = 1'b0;
         last = (i == cyc - 1);
         chk({tag, "_err"},   32'(err_count),   32'(exp_e8[i]));
         chk({tag, "_tot"},   32'(total),       32'(exp_t8[i]));
         chk({tag, "_s_err"}, 32'(s_err_count), 32'(exp_e4[i]));
         chk({tag, "_s_tot"}, 32'(s_total),     32'(exp_t4[i]));
         chk({tag, "_done"},  32'(done), 32'(last));
         chk({tag, "_busy"},  32'(busy), 32'(!last));
         chk({tag, "_pass"},  32'(pass), last ? 32'(ep) : 0);
      end
      chk({tag, "_sf"},     32'(sync_fail),   32'(sf));
      chk({tag, "_s_pass"}, 32'(s_pass),      32'(ep));
      chk({tag, "_s_sf"},   32'(s_sync_fail), 32'(sf));
      {carry_in, sum_in} = 2'($urandom_range(3));
      @(posedge clock); #1;
      chk({tag, "_hold_done"}, 32'(done), 1);
      chk({tag, "_hold_pass"}, 32'(pass), 32'(ep));
      chk({tag, "_hold_err"},  32'(err_count), 32'(exp_e8[cyc-1]));
      chk({tag, "_hold_tot"},  32'(total),     32'(exp_t8[cyc-1]));
   endtask

   initial begin
      int c0;
      clear = 1'b0; start = 1'b0; sum_in = 1'b0; carry_in = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      chk_zero("reset");
      @(negedge clock); clear = 1'b1;
      @(posedge clock); #1;
      chk_zero("idle");

      // Clean stream; narrow instance must clamp total at 15.
      c0 = int'($urandom_range(3));
      build(c0, 0);
      run_seq("clean", -1, -1);
      chk("clean_total16", 32'(total), 16);
      chk("clean_pass",    32'(pass), 1);
      chk("sat_total15",   32'(s_total), 15);

      // Single fault on a phase-0 sample (second group of four), restart from DONE.
      c0 = int'($urandom_range(3));
      build(c0, 0);
      seq[(3 - c0) + 1 + 4] = 2'b10;
      run_seq("fault", -1, -1);
      chk("fault_err1",  32'(err_count), 1);
      chk("fault_tot18", 32'(total), 18);
      chk("fault_pass",  32'(pass), 0);

      // No sync sample ever.
      build(0, 0);
      for (int i = 0; i < seq.size(); i++) seq[i] = 2'b00;
      run_seq("nosync", -1, -1);
      chk("nosync_sf",   32'(sync_fail), 1);
      chk("nosync_pass", 32'(pass), 0);

      // start during CHECK must be ignored.
      c0 = int'($urandom_range(3));
      build(c0, 0);
      run_seq("start_chk", (3 - c0) + 1 + 5, -1);
      chk("start_chk_tot", 32'(total), 16);

      // clear after 7 checked samples, then a clean run.
      c0 = int'($urandom_range(3));
      build(c0, 0);
      run_seq("abort", -1, (3 - c0) + 1 + 7);
      build(int'($urandom_range(3)), 0);
      run_seq("after_abort", -1, -1);
      chk("after_abort_pass", 32'(pass), 1);

      // Random streams with faults and stray start pulses.
      for (int r = 0; r < 24; r++) begin
         build(int'($urandom_range(3)), int'($urandom_range(40)));
         run_seq("rand", int'($urandom_range(20)), -1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
